// File: rtl/ser_rr_arbiter_pkg.sv
// Shared definitions for the serial round-robin block arbiter.
// Byte k of a block sits at bits [k*DW +: DW]; byte 0 (LSB) is streamed first.
package ser_rr_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned NB_DEF    = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/ser_rr_arbiter_if.sv
// Producer-side block strobes plus consumer-side serial byte handshake.
interface ser_rr_arbiter_if
  import ser_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned NB    = NB_DEF
);
  localparam int unsigned SW = $clog2(N_REQ);

  logic [N_REQ-1:0]       STBi;
  logic [N_REQ*NB*DW-1:0] DATi;
  logic [N_REQ-1:0]       ACKi;
  logic                   STBo;
  logic [DW-1:0]          DATo;
  logic                   ACKo;
  logic [SW-1:0]          SRCo;
  logic                   LASTo;

  modport master (
    output STBi, DATi, ACKo,
    input  ACKi, STBo, DATo, SRCo, LASTo
  );

  modport slave (
    input  STBi, DATi, ACKo,
    output ACKi, STBo, DATo, SRCo, LASTo
  );

endinterface

// File: rtl/ser_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly above ptr, else
// lowest request overall. Returns one-hot grant and its binary index.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_c,
  output logic [$clog2(N)-1:0] idx_c,
  output logic                 any_c
);
  localparam int unsigned SW = $clog2(N);

  logic [N-1:0] hi_c;
  logic [N-1:0] src_c;

  always_comb begin
    hi_c  = '0;
    gnt_c = '0;
    idx_c = '0;
    for (int r = 0; r < N; r++) begin
      hi_c[r] = req[r] && (SW'(r) > ptr);
    end
    src_c = (|hi_c) ? hi_c : req;
    // Walk downward so the lowest set bit of src_c wins.
    for (int r = N - 1; r >= 0; r--) begin
      if (src_c[r]) begin
        gnt_c    = '0;
        gnt_c[r] = 1'b1;
        idx_c    = SW'(r);
      end
    end
    any_c = |req;
  end

endmodule

// File: rtl/ser_rr_arbiter.sv
// Shares one serial byte channel between N_REQ block producers: grants one
// round-robin, latches its block, acknowledges it and streams it out.
module ser_rr_arbiter
  import ser_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned NB    = NB_DEF
) (
  input logic            CLK,
  input logic            RST,
  ser_rr_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(N_REQ);
  localparam int unsigned BW = NB * DW;
  localparam int unsigned IW = $clog2(NB);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NB - 1);
  localparam logic [IW-1:0] IDX_PENULT = IW'(NB - 2);

  logic [0:0]       state_q, state_n;
  logic [BW-1:0]    shreg_q, shreg_n;
  logic [IW-1:0]    idx_q,   idx_n;
  logic             stb_q,   stb_n;
  logic             last_q,  last_n;
  logic [N_REQ-1:0] ack_q,   ack_n;
  logic [SW-1:0]    src_q,   src_n;
  logic [SW-1:0]    ptr_q,   ptr_n;

  logic [N_REQ-1:0] pick_gnt_c;
  logic [SW-1:0]    pick_idx_c;
  logic             pick_any_c;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.STBi),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      last_q  <= 1'b0;
      ack_q   <= '0;
      src_q   <= '0;
      ptr_q   <= SW'(N_REQ - 1);
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      idx_q   <= idx_n;
      stb_q   <= stb_n;
      last_q  <= last_n;
      ack_q   <= ack_n;
      src_q   <= src_n;
      ptr_q   <= ptr_n;
    end
  end

  // Next-state and next-output logic; ACKi is a single-cycle pulse by default.
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    idx_n   = idx_q;
    stb_n   = stb_q;
    last_n  = last_q;
    ack_n   = '0;
    src_n   = src_q;
    ptr_n   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          for (int r = 0; r < N_REQ; r++) begin
            if (pick_gnt_c[r]) shreg_n = bus.DATi[r*BW +: BW];
          end
          ack_n   = pick_gnt_c;
          src_n   = pick_idx_c;
          ptr_n   = pick_idx_c;
          idx_n   = '0;
          stb_n   = 1'b1;
          last_n  = 1'b0;
          state_n = ST_XFER;
        end
      end
      ST_XFER: begin
        if (stb_q && bus.ACKo) begin
          if (idx_q == IDX_LAST) begin
            stb_n   = 1'b0;
            last_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            shreg_n = shreg_q >> DW;
            idx_n   = idx_q + IW'(1);
            last_n  = (idx_q == IDX_PENULT);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.ACKi  = ack_q;
  assign bus.STBo  = stb_q;
  assign bus.DATo  = shreg_q[DW-1:0];
  assign bus.SRCo  = src_q;
  assign bus.LASTo = last_q;

endmodule
